// File: rtl/isram_pkg.sv
// Shared types and constants for the fetch/data-side SRAM slaves and interconnect.
package isram_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } isram_state_e;

endpackage

// File: rtl/axi_isram_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances only when stepped.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       step_i,
    output logic [7:0] value_o
);

    // Shift left, feeding back the XOR of the tap bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_o <= SEED;
        end else if (step_i) begin
            value_o <= {value_o[6:0], value_o[7] ^ value_o[5] ^ value_o[4] ^ value_o[3]};
        end
    end

endmodule

// File: rtl/axi_isram.sv
// AXI4-lite read-only instruction SRAM with fixed plus optional random latency.
module axi_isram
    import isram_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int unsigned LAT       = 1,
    parameter bit          RAND_EN   = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     slv_ar_valid_i,
    input  logic [ADDR_W-1:0]        slv_ar_addr_i,
    output logic                     slv_ar_ready_o,
    output logic                     slv_r_valid_o,
    output logic [DATA_W-1:0]        slv_r_data_o,
    output logic [1:0]               slv_r_resp_o,
    input  logic                     slv_r_ready_i,
    input  logic                     ld_we_i,
    input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]        ld_data_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic [DATA_W-1:0] mem [DEPTH];

    isram_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] r_data_d;
    logic [1:0]        r_resp_d;
    logic              r_valid_d;
    logic              ar_ready_d;

    logic              ar_fire;
    logic [7:0]        lfsr_val;
    logic [ADDR_W-1:0] off;
    logic              addr_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [CNT_W-1:0]  rand_add;

    assign ar_fire = slv_ar_valid_i & slv_ar_ready_o;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .step_i  (ar_fire),
        .value_o (lfsr_val)
    );

    // Preload port; memory contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    // Decode the latched address into a word index and an error flag.
    always_comb begin
        off      = addr_q - BASE;
        addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE) || (off >= SPAN);
        rd_idx   = off[IDX_W+1:2];
        rand_add = RAND_EN ? CNT_W'(lfsr_val & 8'h03) : '0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        r_data_d = slv_r_data_o;
        r_resp_d = slv_r_resp_o;
        case (state_q)
            IDLE: begin
                if (ar_fire) begin
                    addr_d  = slv_ar_addr_i;
                    cnt_d   = CNT_W'(LAT) + rand_add;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    r_data_d = addr_err ? '0 : mem[rd_idx];
                    r_resp_d = addr_err ? RESP_SLVERR : RESP_OKAY;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (slv_r_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ar_ready_d = (state_d == IDLE);
        r_valid_d  = (state_d == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            slv_r_data_o   <= '0;
            slv_r_resp_o   <= RESP_OKAY;
            slv_r_valid_o  <= 1'b0;
            slv_ar_ready_o <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            slv_r_data_o   <= r_data_d;
            slv_r_resp_o   <= r_resp_d;
            slv_r_valid_o  <= r_valid_d;
            slv_ar_ready_o <= ar_ready_d;
        end
    end

endmodule

// File: tb/tb_axi_isram.sv
// Scoreboard bench for axi_isram: three configurations sharing one clock.
module tb_axi_isram;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        clk;
    logic        rst      [3];
    logic        ar_valid [3];
    logic [31:0] ar_addr  [3];
    logic        ar_ready [3];
    logic        r_valid  [3];
    logic [31:0] r_data   [3];
    logic [1:0]  r_resp   [3];
    logic        r_ready  [3];
    logic        ld_we    [3];
    logic [9:0]  ld_addr  [3];
    logic [31:0] ld_data  [3];

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    int          lat1  [100];
    logic [31:0] addrs [100];
    logic [7:0]  m_lfsr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axi_isram #(.DEPTH(1024), .BASE(32'h8000_0000), .LAT(1), .RAND_EN(1'b0), .LFSR_SEED(8'hA5)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .slv_ar_valid_i(ar_valid[0]), .slv_ar_addr_i(ar_addr[0]),
        .slv_ar_ready_o(ar_ready[0]), .slv_r_valid_o(r_valid[0]), .slv_r_data_o(r_data[0]),
        .slv_r_resp_o(r_resp[0]), .slv_r_ready_i(r_ready[0]), .ld_we_i(ld_we[0]),
        .ld_addr_i(ld_addr[0]), .ld_data_i(ld_data[0]));

    axi_isram #(.DEPTH(1024), .BASE(32'h8000_0000), .LAT(0), .RAND_EN(1'b0), .LFSR_SEED(8'hA5)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .slv_ar_valid_i(ar_valid[1]), .slv_ar_addr_i(ar_addr[1]),
        .slv_ar_ready_o(ar_ready[1]), .slv_r_valid_o(r_valid[1]), .slv_r_data_o(r_data[1]),
        .slv_r_resp_o(r_resp[1]), .slv_r_ready_i(r_ready[1]), .ld_we_i(ld_we[1]),
        .ld_addr_i(ld_addr[1]), .ld_data_i(ld_data[1]));

    axi_isram #(.DEPTH(1024), .BASE(32'h8000_0000), .LAT(2), .RAND_EN(1'b1), .LFSR_SEED(8'hA5)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .slv_ar_valid_i(ar_valid[2]), .slv_ar_addr_i(ar_addr[2]),
        .slv_ar_ready_o(ar_ready[2]), .slv_r_valid_o(r_valid[2]), .slv_r_data_o(r_data[2]),
        .slv_r_resp_o(r_resp[2]), .slv_r_ready_i(r_ready[2]), .ld_we_i(ld_we[2]),
        .ld_addr_i(ld_addr[2]), .ld_data_i(ld_data[2]));

    // One comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [9:0] idx, input logic [31:0] data);
        ld_we[i]   = 1'b1;
        ld_addr[i] = idx;
        ld_data[i] = data;
        step();
        ld_we[i]   = 1'b0;
    endtask

    // Issue one read, compare against the scoreboard, optionally stall R and pre-assert the next AR.
    task automatic do_read(input int i, input logic [31:0] addr, input logic [31:0] ed,
                           input logic [1:0] er, input int hold, input bit keep,
                           input logic [31:0] naddr, output int lat_o);
        exp_t e;
        bit   acc;
        int   guard;
        sb.push_back({ed, er});
        ar_valid[i] = 1'b1;
        ar_addr[i]  = addr;
        r_ready[i]  = (hold == 0);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            acc = ar_ready[i];
            step();
            guard++;
        end
        check("ar_accept", 32'(acc), 32'd1);
        check("ar_accept_edge", 32'(guard), 32'd1);
        ar_valid[i] = 1'b0;
        lat_o = 0;
        while (!r_valid[i] && lat_o < 40) begin
            check("ar_ready_busy", 32'(ar_ready[i]), 32'd0);
            step();
            lat_o++;
        end
        check("r_valid_seen", 32'(r_valid[i]), 32'd1);
        e = sb.pop_front();
        check("r_data", r_data[i], e.data);
        check("r_resp", 32'(r_resp[i]), 32'(e.resp));
        if (keep) begin
            ar_valid[i] = 1'b1;
            ar_addr[i]  = naddr;
        end
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", 32'(r_valid[i]), 32'd1);
            check("hold_data", r_data[i], e.data);
            check("hold_resp", 32'(r_resp[i]), 32'(e.resp));
            check("hold_ar_ready", 32'(ar_ready[i]), 32'd0);
        end
        r_ready[i] = 1'b1;
        step();
        r_ready[i] = 1'b0;
        check("r_valid_drop", 32'(r_valid[i]), 32'd0);
        check("ar_ready_back", 32'(ar_ready[i]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; ar_valid[i] = 1'b0; ar_addr[i] = '0; r_ready[i] = 1'b0;
            ld_we[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_ar_ready", 32'(ar_ready[i]), 32'd1);
            check("rst_r_valid", 32'(r_valid[i]), 32'd0);
            check("rst_r_data", r_data[i], 32'd0);
            check("rst_r_resp", 32'(r_resp[i]), 32'd0);
        end

        // Basic LAT=1 read and a stalled response with the next AR already pending.
        load(0, 10'd0, 32'h0010_0073);
        load(0, 10'd1, 32'hCAFE_0001);
        load(0, 10'd1023, 32'hDEAD_BEEF);
        do_read(0, 32'h8000_0000, 32'h0010_0073, 2'b00, 0, 1'b0, 32'h0, lat);
        check("lat1_first", 32'(lat), 32'd2);
        do_read(0, 32'h8000_0000, 32'h0010_0073, 2'b00, 5, 1'b1, 32'h8000_0004, lat);
        do_read(0, 32'h8000_0004, 32'hCAFE_0001, 2'b00, 0, 1'b0, 32'h0, lat);
        check("lat1_second", 32'(lat), 32'd2);

        // Address decode boundaries.
        do_read(0, 32'h8000_0FFC, 32'hDEAD_BEEF, 2'b00, 0, 1'b0, 32'h0, lat);
        do_read(0, 32'h8000_1000, 32'h0, 2'b10, 0, 1'b0, 32'h0, lat);
        do_read(0, 32'h8000_0002, 32'h0, 2'b10, 0, 1'b0, 32'h0, lat);
        do_read(0, 32'h7FFF_FFFC, 32'h0, 2'b10, 0, 1'b0, 32'h0, lat);

        // LAT=0 back-to-back reads with R always ready.
        for (int k = 0; k < 4; k++) load(1, 10'(k), 32'(k + 1));
        for (int k = 0; k < 4; k++) begin
            do_read(1, 32'h8000_0000 + 32'(4 * k), 32'(k + 1), 2'b00, 0, 1'b0, 32'h0, lat);
            check("lat0", 32'(lat), 32'd1);
        end

        // LAT=0: a load committed in the read cycle is not seen, but is seen by the next read.
        ar_valid[1] = 1'b1;
        ar_addr[1]  = 32'h8000_0000;
        r_ready[1]  = 1'b1;
        step();
        ar_valid[1] = 1'b0;
        ld_we[1] = 1'b1; ld_addr[1] = 10'd0; ld_data[1] = 32'h0000_0099;
        step();
        ld_we[1] = 1'b0;
        check("same_cycle_valid", 32'(r_valid[1]), 32'd1);
        check("same_cycle_old", r_data[1], 32'd1);
        step();
        r_ready[1] = 1'b0;
        do_read(1, 32'h8000_0000, 32'h0000_0099, 2'b00, 0, 1'b0, 32'h0, lat);

        // Reset while waiting drops the transaction; memory survives.
        ar_valid[0] = 1'b1;
        ar_addr[0]  = 32'h8000_0000;
        step();
        ar_valid[0] = 1'b0;
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("midrst_ar_ready", 32'(ar_ready[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("midrst_no_valid", 32'(r_valid[0]), 32'd0);
            step();
        end
        do_read(0, 32'h8000_0000, 32'h0010_0073, 2'b00, 0, 1'b0, 32'h0, lat);

        // Random extra delay: latency follows the seeded LFSR and repeats after reset.
        for (int k = 0; k < 16; k++) load(2, 10'(k), 32'h1000_0000 + 32'(k * 7));
        m_lfsr = 8'hA5;
        for (int n = 0; n < 100; n++) begin
            int w;
            w = int'($urandom_range(0, 15));
            addrs[n] = 32'h8000_0000 + 32'(4 * w);
            do_read(2, addrs[n], 32'h1000_0000 + 32'(w * 7), 2'b00, 0, 1'b0, 32'h0, lat);
            check("rand_lat_model", 32'(lat), 32'(3 + int'(m_lfsr[1:0])));
            check("rand_lat_range", 32'((lat >= 3) && (lat <= 6)), 32'd1);
            lat1[n] = lat;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        for (int n = 0; n < 100; n++) begin
            do_read(2, addrs[n], 32'h1000_0000 + 32'(((addrs[n] - 32'h8000_0000) >> 2) * 7),
                    2'b00, 0, 1'b0, 32'h0, lat);
            check("rand_lat_repeat", 32'(lat), 32'(lat1[n]));
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
